// File: rtl/cpu_pkg.sv
// Shared opcode map, FSM states and helpers for the
// parametrised accumulator core.
package cpu_pkg;

   localparam logic [3:0] OP_ADD  = 4'd0;
   localparam logic [3:0] OP_SUB  = 4'd1;
   localparam logic [3:0] OP_XCHG = 4'd2;
   localparam logic [3:0] OP_IN   = 4'd3;
   localparam logic [3:0] OP_OUT  = 4'd4;
   localparam logic [3:0] OP_INC  = 4'd5;
   localparam logic [3:0] OP_MOVM = 4'd6;
   localparam logic [3:0] OP_MOVI = 4'd7;
   localparam logic [3:0] OP_JZ   = 4'd8;
   localparam logic [3:0] OP_PUSH = 4'd9;
   localparam logic [3:0] OP_POP  = 4'd10;
   localparam logic [3:0] OP_RCL  = 4'd11;
   localparam logic [3:0] OP_CALL = 4'd12;
   localparam logic [3:0] OP_RET  = 4'd13;
   localparam logic [3:0] OP_AND  = 4'd14;
   localparam logic [3:0] OP_HLT  = 4'd15;

   typedef enum logic [2:0] {
      FETCH,
      EXEC,
      IN_WAIT,
      OUT_WAIT,
      HALTED
   } state_t;

   function automatic int max_int(input int x, input int y);
      return (x > y) ? x : y;
   endfunction

endpackage

// File: rtl/cpu_stack.sv
// LIFO used for PUSH/POP and CALL/RET; sp counts filled entries.
// Push on full and pop on empty are silently ignored.
module cpu_stack
   import cpu_pkg::*;
#(
   parameter int SW     = 4,
   parameter int SDEPTH = 16
) (
   input  logic          osc_clock,
   input  logic          reset,
   input  logic          push,
   input  logic          pop,
   input  logic [SW-1:0] din,
   output logic [SW-1:0] dout,
   output logic          full,
   output logic          empty
);

   localparam int PW = $clog2(SDEPTH + 1);
   localparam int IW = (SDEPTH > 1) ? $clog2(SDEPTH) : 1;

   logic [SW-1:0] mem [SDEPTH];
   logic [PW-1:0] sp;

   assign full  = (sp == PW'(SDEPTH));
   assign empty = (sp == '0);
   assign dout  = empty ? '0 : mem[IW'(sp - 1'b1)];

   always_ff @(posedge osc_clock or posedge reset) begin
      if (reset) begin
         sp <= '0;
      end else if (push && !full) begin
         sp <= sp + 1'b1;
      end else if (pop && !empty) begin
         sp <= sp - 1'b1;
      end
   end

   // Storage is deliberately not reset.
   always_ff @(posedge osc_clock) begin
      if (push && !full) begin
         mem[IW'(sp)] <= din;
      end
   end

endmodule

// File: rtl/param_cpu_core.sv
// Accumulator CPU core: fetch/execute FSM, flags, DMEM and
// valid/ready handshaked input and output ports.
module param_cpu_core
   import cpu_pkg::*;
#(
   parameter int DW     = 4,
   parameter int AW     = 4,
   parameter int SDEPTH = 16
) (
   input  logic          osc_clock,
   input  logic          reset,
   output logic [AW-1:0] imem_addr,
   input  logic [AW+3:0] imem_data,
   input  logic          dm_we,
   input  logic [AW-1:0] dm_waddr,
   input  logic [DW-1:0] dm_wdata,
   input  logic [DW-1:0] in_data,
   input  logic          in_valid,
   output logic          in_ready,
   output logic [DW-1:0] out_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic          halted,
   output logic          fault
);

   localparam int SW = max_int(DW, AW);

   state_t        state;
   logic [AW-1:0] ip;
   logic [AW+3:0] ir;
   logic [DW-1:0] a;
   logic [DW-1:0] b;
   logic          zf;
   logic          cf;
   logic [DW-1:0] dmem [2**AW];

   logic [3:0]    op;
   logic [AW-1:0] k;
   logic [DW-1:0] mem_word;
   logic [DW:0]   add_r;
   logic [DW:0]   sub_r;
   logic [DW:0]   inc_r;
   logic [DW-1:0] and_r;
   logic [DW-1:0] rcl_r;
   logic [DW-1:0] imm_r;
   logic          exec;
   logic          st_push;
   logic          st_pop;
   logic [SW-1:0] st_din;
   logic [SW-1:0] st_dout;
   logic          st_full;
   logic          st_empty;

   assign imem_addr = ip;
   assign op        = ir[AW+3:AW];
   assign k         = ir[AW-1:0];
   assign mem_word  = dmem[k];
   assign add_r     = {1'b0, a} + {1'b0, b};
   assign sub_r     = {1'b0, a} - {1'b0, b};
   assign inc_r     = {1'b0, a} + (DW+1)'(1);
   assign and_r     = a & mem_word;
   assign rcl_r     = {b[DW-2:0], b[DW-1]};
   assign imm_r     = DW'(k);
   assign exec      = (state == EXEC);

   assign st_push = exec && !st_full
                    && (op == OP_PUSH || op == OP_CALL);
   assign st_pop  = exec && !st_empty
                    && (op == OP_POP || op == OP_RET);
   assign st_din  = (op == OP_CALL) ? SW'(ip) : SW'(b);

   cpu_stack #(
      .SW     (SW),
      .SDEPTH (SDEPTH)
   ) u_stack (
      .osc_clock (osc_clock),
      .reset     (reset),
      .push      (st_push),
      .pop       (st_pop),
      .din       (st_din),
      .dout      (st_dout),
      .full      (st_full),
      .empty     (st_empty)
   );

   // Preload port; a same-cycle MOV/AND sees the old word.
   always_ff @(posedge osc_clock) begin
      if (dm_we) begin
         dmem[dm_waddr] <= dm_wdata;
      end
   end

   always_ff @(posedge osc_clock or posedge reset) begin
      if (reset) begin
         state     <= FETCH;
         ip        <= '0;
         ir        <= '0;
         a         <= '0;
         b         <= '0;
         zf        <= 1'b0;
         cf        <= 1'b0;
         in_ready  <= 1'b0;
         out_valid <= 1'b0;
         out_data  <= '0;
         halted    <= 1'b0;
         fault     <= 1'b0;
      end else begin
         unique case (state)
            FETCH: begin
               ir    <= imem_data;
               ip    <= ip + 1'b1;
               state <= EXEC;
            end
            EXEC: begin
               state <= FETCH;
               unique case (op)
                  OP_ADD: begin
                     a  <= add_r[DW-1:0];
                     cf <= add_r[DW];
                     zf <= (add_r[DW-1:0] == '0);
                  end
                  OP_SUB: begin
                     a  <= sub_r[DW-1:0];
                     cf <= sub_r[DW];
                     zf <= (sub_r[DW-1:0] == '0);
                  end
                  OP_XCHG: begin
                     a  <= b;
                     b  <= a;
                     zf <= (a == '0);
                  end
                  OP_IN: begin
                     in_ready <= 1'b1;
                     state    <= IN_WAIT;
                  end
                  OP_OUT: begin
                     out_valid <= 1'b1;
                     out_data  <= a;
                     state     <= OUT_WAIT;
                  end
                  OP_INC: begin
                     a  <= inc_r[DW-1:0];
                     cf <= inc_r[DW];
                     zf <= (inc_r[DW-1:0] == '0);
                  end
                  OP_MOVM: begin
                     a  <= mem_word;
                     zf <= (mem_word == '0);
                  end
                  OP_MOVI: begin
                     a  <= imm_r;
                     zf <= (imm_r == '0);
                  end
                  OP_JZ: begin
                     if (zf) ip <= k;
                  end
                  OP_PUSH: begin
                     if (st_full) begin
                        fault  <= 1'b1;
                        halted <= 1'b1;
                        state  <= HALTED;
                     end else begin
                        zf <= (b == '0);
                     end
                  end
                  OP_POP: begin
                     if (st_empty) begin
                        fault  <= 1'b1;
                        halted <= 1'b1;
                        state  <= HALTED;
                     end else begin
                        b  <= st_dout[DW-1:0];
                        zf <= (st_dout[DW-1:0] == '0);
                     end
                  end
                  OP_RCL: begin
                     b  <= rcl_r;
                     zf <= (rcl_r == '0);
                  end
                  OP_CALL: begin
                     if (st_full) begin
                        fault  <= 1'b1;
                        halted <= 1'b1;
                        state  <= HALTED;
                     end else begin
                        ip <= k;
                     end
                  end
                  OP_RET: begin
                     if (st_empty) begin
                        fault  <= 1'b1;
                        halted <= 1'b1;
                        state  <= HALTED;
                     end else begin
                        ip <= st_dout[AW-1:0];
                     end
                  end
                  OP_AND: begin
                     a  <= and_r;
                     zf <= (and_r == '0);
                  end
                  OP_HLT: begin
                     halted <= 1'b1;
                     fault  <= 1'b0;
                     state  <= HALTED;
                  end
               endcase
            end
            IN_WAIT: begin
               if (in_valid && in_ready) begin
                  a        <= in_data;
                  zf       <= (in_data == '0);
                  in_ready <= 1'b0;
                  state    <= FETCH;
               end
            end
            OUT_WAIT: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= FETCH;
               end
            end
            HALTED: begin
               state <= HALTED;
            end
            default: begin
               state <= HALTED;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_param_cpu_core.sv
// Directed bench for param_cpu_core: program table plus
// hand sequences for handshakes, jumps, calls and reset.
module tb_param_cpu_core;
   import cpu_pkg::*;

   logic       osc_clock = 1'b0;
   logic       reset;
   logic [3:0] imem_addr;
   logic [7:0] imem_data;
   logic       dm_we;
   logic [3:0] dm_waddr;
   logic [3:0] dm_wdata;
   logic [3:0] in_data;
   logic       in_valid;
   logic       in_ready;
   logic [3:0] out_data;
   logic       out_valid;
   logic       out_ready;
   logic       halted;
   logic       fault;

   logic [3:0] imem_addr2;
   logic [7:0] imem_data2;
   logic       in_ready2;
   logic [3:0] out_data2;
   logic       out_valid2;
   logic       halted2;
   logic       fault2;

   logic [7:0] rom  [16];
   logic [7:0] rom2 [16];

   int total = 0;
   int bad   = 0;

   typedef struct {
      string       name;
      logic [63:0] prog;
      logic [3:0]  ea;
      logic [3:0]  eb;
      logic        ezf;
      logic        ecf;
      logic        eflt;
   } vec_t;

   vec_t vecs [13];

   always #5 osc_clock = ~osc_clock;

   assign imem_data  = rom[imem_addr];
   assign imem_data2 = rom2[imem_addr2];

   param_cpu_core #(.DW(4), .AW(4), .SDEPTH(16)) dut (
      .osc_clock (osc_clock),
      .reset     (reset),
      .imem_addr (imem_addr),
      .imem_data (imem_data),
      .dm_we     (dm_we),
      .dm_waddr  (dm_waddr),
      .dm_wdata  (dm_wdata),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .halted    (halted),
      .fault     (fault)
   );

   param_cpu_core #(.DW(4), .AW(4), .SDEPTH(2)) dut2 (
      .osc_clock (osc_clock),
      .reset     (reset),
      .imem_addr (imem_addr2),
      .imem_data (imem_data2),
      .dm_we     (1'b0),
      .dm_waddr  (4'd0),
      .dm_wdata  (4'd0),
      .in_data   (4'd0),
      .in_valid  (1'b0),
      .in_ready  (in_ready2),
      .out_data  (out_data2),
      .out_valid (out_valid2),
      .out_ready (1'b1),
      .halted    (halted2),
      .fault     (fault2)
   );

   task automatic chk(input string name,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, got, exp);
      end
   endtask

   task automatic clr_rom();
      for (int i = 0; i < 16; i++) rom[i] = 8'h00;
   endtask

   task automatic run_start();
      reset = 1'b1;
      @(negedge osc_clock);
      reset = 1'b0;
   endtask

   task automatic wait_halt(input string name);
      int n = 0;
      while (!halted && n < 60) begin
         @(negedge osc_clock);
         n++;
      end
      chk({name, "_halt"}, 32'(halted), 32'd1);
   endtask

   task automatic wait_outv(input string name);
      int n = 0;
      while (!out_valid && n < 40) begin
         @(negedge osc_clock);
         n++;
      end
      chk({name, "_outv"}, 32'(out_valid), 32'd1);
   endtask

   initial begin
      reset     = 1'b1;
      dm_we     = 1'b0;
      dm_waddr  = '0;
      dm_wdata  = '0;
      in_data   = '0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      clr_rom();
      for (int i = 0; i < 16; i++) rom2[i] = 8'h00;
      rom2[0] = 8'h90;
      rom2[1] = 8'h90;
      rom2[2] = 8'h90;
      rom2[3] = 8'hF0;

      vecs[0]  = '{"add",      64'h000000F000612060, 4'hB, 4'h5, 1'b0, 1'b0, 1'b0};
      vecs[1]  = '{"add_cy",   64'h000000F00071207F, 4'h0, 4'hF, 1'b1, 1'b1, 1'b0};
      vecs[2]  = '{"sub_bw",   64'h000000F010712073, 4'hE, 4'h3, 1'b0, 1'b1, 1'b0};
      vecs[3]  = '{"sub_zero", 64'h000000F010752075, 4'h0, 4'h5, 1'b1, 1'b0, 1'b0};
      vecs[4]  = '{"inc_wrap", 64'h00000000F071507F, 4'h1, 4'h0, 1'b0, 1'b1, 1'b0};
      vecs[5]  = '{"and",      64'h0000000000F0E27F, 4'hC, 4'h0, 1'b0, 1'b0, 1'b0};
      vecs[6]  = '{"and_zero", 64'h0000000000F0E273, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0};
      vecs[7]  = '{"rcl",      64'h000000F0B0502079, 4'h1, 4'h3, 1'b0, 1'b0, 1'b0};
      vecs[8]  = '{"push_pop", 64'h0000F0A02090207A, 4'hA, 4'hA, 1'b0, 1'b0, 1'b0};
      vecs[9]  = '{"pop_mt",   64'h000000000000A073, 4'h3, 4'h0, 1'b0, 1'b0, 1'b1};
      vecs[10] = '{"hlt",      64'h00000000000000F0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0};
      vecs[11] = '{"mem_rd",   64'h000000000000F061, 4'h6, 4'h0, 1'b0, 1'b0, 1'b0};
      vecs[12] = '{"push_zf",  64'h0000000000F09071, 4'h1, 4'h0, 1'b1, 1'b0, 1'b0};

      // DMEM preload under reset
      @(negedge osc_clock);
      dm_we = 1'b1;
      dm_waddr = 4'd0; dm_wdata = 4'd5; @(negedge osc_clock);
      dm_waddr = 4'd1; dm_wdata = 4'd6; @(negedge osc_clock);
      dm_waddr = 4'd2; dm_wdata = 4'hC; @(negedge osc_clock);
      dm_we = 1'b0;

      chk("rst_outs",
          32'({in_ready, out_valid, halted, fault, out_data, imem_addr}),
          32'd0);
      chk("rst_state", 32'(dut.state), 32'(FETCH));

      for (int i = 0; i < 13; i++) begin
         for (int j = 0; j < 16; j++)
            rom[j] = (j < 8) ? vecs[i].prog[8*j +: 8] : 8'h00;
         run_start();
         wait_halt(vecs[i].name);
         chk(vecs[i].name,
             32'({dut.a, dut.b, dut.zf, dut.cf, fault}),
             32'({vecs[i].ea, vecs[i].eb, vecs[i].ezf,
                  vecs[i].ecf, vecs[i].eflt}));
      end

      // OUT handshake with back-pressure
      clr_rom();
      rom[0] = 8'h60; rom[1] = 8'h20; rom[2] = 8'h61;
      rom[3] = 8'h00; rom[4] = 8'h40; rom[5] = 8'hF0;
      run_start();
      wait_outv("out");
      chk("out_data", 32'(out_data), 32'd11);
      for (int i = 0; i < 3; i++) begin
         @(negedge osc_clock);
         chk("out_hold", 32'({out_valid, out_data}), 32'h1B);
      end
      out_ready = 1'b1;
      @(posedge osc_clock);
      #1 out_ready = 1'b0;
      @(negedge osc_clock);
      chk("out_drop", 32'(out_valid), 32'd0);
      wait_halt("out");
      chk("out_fault", 32'(fault), 32'd0);

      // SDEPTH=2 instance: third push faults
      run_start();
      repeat (4) @(posedge osc_clock);
      @(negedge osc_clock);
      chk("s2_two", 32'({dut2.u_stack.sp, fault2}), 32'({2'd2, 1'b0}));
      repeat (4) @(negedge osc_clock);
      chk("s2_flt", 32'({dut2.u_stack.sp, halted2, fault2}),
          32'({2'd2, 1'b1, 1'b1}));

      // JZ taken after INC wraps
      clr_rom();
      rom[0] = 8'h7F; rom[1] = 8'h50; rom[2] = 8'h89;
      rom[9] = 8'h71; rom[10] = 8'hF0;
      run_start();
      repeat (6) @(posedge osc_clock);
      @(negedge osc_clock);
      chk("jz_addr", 32'(imem_addr), 32'd9);
      wait_halt("jz");
      chk("jz_flags", 32'({dut.a, dut.zf, dut.cf}), 32'({4'h1, 1'b0, 1'b1}));

      // CALL / RET
      clr_rom();
      rom[0] = 8'h71; rom[1] = 8'h72; rom[2] = 8'hC8;
      rom[3] = 8'hF0; rom[8] = 8'hD0;
      run_start();
      repeat (6) @(posedge osc_clock);
      @(negedge osc_clock);
      chk("call", 32'({dut.u_stack.sp, imem_addr}), 32'({5'd1, 4'd8}));
      repeat (2) @(posedge osc_clock);
      @(negedge osc_clock);
      chk("ret", 32'({dut.u_stack.sp, imem_addr}), 32'({5'd0, 4'd3}));
      wait_halt("call");
      chk("call_end", 32'({fault, dut.a}), 32'({1'b0, 4'h2}));

      // IN with delayed valid
      clr_rom();
      rom[0] = 8'h30; rom[1] = 8'hF0;
      run_start();
      repeat (2) @(posedge osc_clock);
      for (int i = 0; i < 5; i++) begin
         @(negedge osc_clock);
         chk("in_wait", 32'(in_ready), 32'd1);
      end
      in_data  = 4'd9;
      in_valid = 1'b1;
      @(posedge osc_clock);
      #1 in_valid = 1'b0;
      in_data = 4'd0;
      @(negedge osc_clock);
      chk("in_xfer", 32'({in_ready, dut.a, dut.zf}),
          32'({1'b0, 4'd9, 1'b0}));
      wait_halt("in");

      // Reset during OUT_WAIT
      clr_rom();
      rom[0] = 8'h75; rom[1] = 8'h40; rom[2] = 8'hF0;
      run_start();
      wait_outv("rst");
      #2 reset = 1'b1;
      #1 chk("rst_async", 32'(out_valid), 32'd0);
      @(negedge osc_clock);
      reset = 1'b0;
      #1 chk("rst_after",
             32'({imem_addr, dut.a, dut.b, out_valid}), 32'd0);
      chk("rst_fetch", 32'(dut.state), 32'(FETCH));

      // Read-before-write on DMEM
      clr_rom();
      rom[0] = 8'h60; rom[1] = 8'hF0;
      run_start();
      @(posedge osc_clock);
      #1 dm_we = 1'b1;
      dm_waddr = 4'd0;
      dm_wdata = 4'd7;
      @(posedge osc_clock);
      #1 dm_we = 1'b0;
      wait_halt("rbw");
      chk("rbw_old", 32'(dut.a), 32'd5);
      run_start();
      wait_halt("rbw2");
      chk("rbw_new", 32'(dut.a), 32'd7);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
